// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 operator run controller.
// Holds the run-state encoding and the default debounce length.
package slc3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    RESUME = 2'd3
  } run_state_t;

  // 1 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, registered rise pulse.
// Ports: Clk, Reset_n, btn_raw (async raw), level (debounced), rise (1-cycle).
module btn_conditioner
  import slc3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  // Counter measures how long the synced input has disagreed with
  // the debounced level; any agreement restarts the measurement.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/slc3_run_ctrl.sv
// Operator run controller: conditions Run/Continue and sequences the CPU.
// Ports: Clk, Reset_n, Run, Continue, pause_req in; cpu_en, start_pulse,
// cont_pulse, state_o, run_db, cont_db out.
module slc3_run_ctrl
  import slc3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic       pause_req,
  output logic       cpu_en,
  output logic       start_pulse,
  output logic       cont_pulse,
  output logic [1:0] state_o,
  output logic       run_db,
  output logic       cont_db
);

  logic run_rise, cont_rise;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_run (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .btn_raw(Run),
    .level  (run_db),
    .rise   (run_rise)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_cont (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .btn_raw(Continue),
    .level  (cont_db),
    .rise   (cont_rise)
  );

  run_state_t state_q, state_d;
  logic       start_q, start_d;
  logic       cont_q, cont_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cont_q  <= cont_d;
    end
  end

  // Run restarts from anywhere; RESUME ignores pause_req for one
  // cycle so the CPU has time to leave its PAUSE state.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    cont_d  = 1'b0;
    if (run_rise) begin
      state_d = RUN;
      start_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (pause_req) state_d = PAUSE;
        end
        PAUSE: begin
          if (cont_rise) begin
            state_d = RESUME;
            cont_d  = 1'b1;
          end
        end
        RESUME: state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign cpu_en      = (state_q == RUN) || (state_q == RESUME);
  assign start_pulse = start_q;
  assign cont_pulse  = cont_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_slc3_run_ctrl.sv
// Bench for slc3_run_ctrl with a short debounce.
// Reference model plus directed literal checks.
module tb_slc3_run_ctrl;

  localparam int DB = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Run = 1'b0;
  logic       Continue = 1'b0;
  logic       pause_req = 1'b0;
  logic       cpu_en, start_pulse, cont_pulse, run_db, cont_db;
  logic [1:0] state_o;

  int tests = 0;
  int fails = 0;

  slc3_run_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Run        (Run),
    .Continue   (Continue),
    .pause_req  (pause_req),
    .cpu_en     (cpu_en),
    .start_pulse(start_pulse),
    .cont_pulse (cont_pulse),
    .state_o    (state_o),
    .run_db     (run_db),
    .cont_db    (cont_db)
  );

  always #5 Clk = ~Clk;

  // Model: a debounced level flips when the raw samples taken 2..DB+1
  // edges ago all disagree with it. FSM acts on last cycle's rises.
  bit       rh [0:DB];
  bit       ch [0:DB];
  int       m_st = 0;
  bit       m_start = 0, m_cont = 0;
  bit       m_rdb = 0, m_cdb = 0, m_rrise = 0, m_crise = 0;

  function automatic bit flips(bit h [0:DB], bit lvl);
    for (int i = 1; i <= DB; i++)
      if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_st = 0; m_start = 0; m_cont = 0;
      m_rdb = 0; m_cdb = 0; m_rrise = 0; m_crise = 0;
      for (int i = 0; i <= DB; i++) begin
        rh[i] = 0; ch[i] = 0;
      end
    end else begin
      m_start = 0;
      m_cont  = 0;
      if (m_rrise) begin
        m_st = 1; m_start = 1;
      end else if (m_st == 2 && m_crise) begin
        m_st = 3; m_cont = 1;
      end else if (m_st == 3) begin
        m_st = 1;
      end else if (m_st == 1 && pause_req) begin
        m_st = 2;
      end
      m_rrise = 0;
      m_crise = 0;
      if (flips(rh, m_rdb)) begin
        m_rdb = !m_rdb; m_rrise = m_rdb;
      end
      if (flips(ch, m_cdb)) begin
        m_cdb = !m_cdb; m_crise = m_cdb;
      end
      for (int i = DB; i > 0; i--) begin
        rh[i] = rh[i-1]; ch[i] = ch[i-1];
      end
      rh[0] = Run;
      ch[0] = Continue;
    end
  end

  always @(negedge Clk) begin
    if (Reset_n) begin
      logic [6:0] act, exp;
      act = {cpu_en, start_pulse, cont_pulse, state_o, run_db, cont_db};
      exp = {(m_st == 1 || m_st == 3), m_start, m_cont, 2'(m_st),
             m_rdb, m_cdb};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL model t=%0t got=%b expected=%b", $time, act, exp);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  int n, n2, at;
  bit seen;

  initial begin
    repeat (3) tick();
    chk("rst_state", state_o, 0);
    chk("rst_outs", {cpu_en, start_pulse, cont_pulse, run_db, cont_db}, 0);
    Reset_n = 1'b1;
    tick();

    // Run glitch of two samples
    Run = 1'b1; tick(); tick(); Run = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start_pulse || run_db || state_o != 0) seen = 1;
    end
    chk("glitch_no_effect", seen, 0);

    // Continue in IDLE
    Continue = 1'b1; n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cont_pulse) n++;
    end
    chk("idle_cont_pulses", n, 0);
    chk("idle_cont_state", state_o, 0);
    chk("idle_cont_db", cont_db, 1);
    Continue = 1'b0;
    repeat (8) tick();

    // Run press: pulse 6 cycles after the first sampling edge
    Run = 1'b1; n = 0; at = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start_pulse) begin n++; at = i; end
    end
    chk("run_pulses", n, 1);
    chk("run_latency", at, 6);
    chk("run_state", state_o, 1);
    chk("run_cpu_en", cpu_en, 1);
    Run = 1'b0;
    repeat (8) tick();

    // Continue in RUN
    Continue = 1'b1; n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cont_pulse) n++;
    end
    chk("run_cont_pulses", n, 0);
    chk("run_cont_state", state_o, 1);
    Continue = 1'b0;
    repeat (8) tick();

    // Pause, then continue and drop pause_req on the pulse
    pause_req = 1'b1; tick();
    chk("pause_state", state_o, 2);
    chk("pause_cpu_en", cpu_en, 0);
    Continue = 1'b1; n = 0; at = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cont_pulse) begin
        n++; at = i;
        chk("resume_state", state_o, 3);
        chk("resume_cpu_en", cpu_en, 1);
        pause_req = 1'b0;
      end
    end
    chk("cont_pulses", n, 1);
    chk("cont_latency", at, 6);
    chk("after_resume_state", state_o, 1);
    Continue = 1'b0;
    repeat (8) tick();

    // pause_req held through RESUME: back to PAUSE; long hold, one pulse
    pause_req = 1'b1; tick();
    Continue = 1'b1; n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cont_pulse) n++;
    end
    chk("held_cont_pulses", n, 1);
    chk("repause_state", state_o, 2);
    Continue = 1'b0;
    repeat (8) tick();

    // Run and Continue together in PAUSE
    Run = 1'b1; Continue = 1'b1; n = 0; n2 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cont_pulse) n2++;
      if (start_pulse) begin
        n++;
        chk("both_state", state_o, 1);
        pause_req = 1'b0;
      end
    end
    chk("both_start", n, 1);
    chk("both_cont", n2, 0);
    Run = 1'b0; Continue = 1'b0;
    repeat (8) tick();

    // Async reset while in RESUME
    pause_req = 1'b1; tick();
    Continue = 1'b1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (state_o == 3) seen = 1;
    end
    chk("reach_resume", seen, 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("arst_state", state_o, 0);
    chk("arst_outs", {cpu_en, start_pulse, cont_pulse, run_db, cont_db}, 0);
    Continue = 1'b0; pause_req = 1'b0;
    tick();
    Reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start_pulse || cont_pulse || state_o != 0) seen = 1;
    end
    chk("post_rst_quiet", seen, 0);
    Run = 1'b1; n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start_pulse) n++;
    end
    chk("fresh_run_pulses", n, 1);
    chk("fresh_run_state", state_o, 1);
    Run = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slc3_run_ctrl.md
Name: slc3_run_ctrl

Overview:
- Operator-side run controller for the SLC-3 top level. It is the consumer of the Run/Continue push-button stimulus.
- Per button: synchronises, debounces and edge-detects the raw signal.
- A small FSM then sequences the CPU through halted / running / paused.
- Drives CPU enable, start and continue pulses, plus status for the LEDs. Sits between the board buttons and the slc3 datapath/control.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required before a debounced level changes (1 ms at 100 MHz). Benches override to 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width.

Ports:
- Clk  in  1  system clock, all logic rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  raw Run button, active-high, asynchronous to Clk.
- Continue  in  1  raw Continue button, active-high, asynchronous to Clk.
- pause_req  in  1  level from CPU control; high while the CPU sits in a PAUSE state.
- cpu_en  out  1  CPU may advance (high in RUN and RESUME).
- start_pulse  out  1  one-cycle pulse; CPU resets PC/state and starts.
- cont_pulse  out  1  one-cycle pulse; CPU leaves PAUSE.
- state_o  out  2  current FSM state encoding, for LED display.
- run_db  out  1  debounced Run level (debug/LED).
- cont_db  out  1  debounced Continue level (debug/LED).

Behaviour:
- Reset (Reset_n low, async):
  - sync flops 0, debounce counters 0, debounced levels 0;
  - state IDLE;
  - cpu_en = start_pulse = cont_pulse = 0, run_db = cont_db = 0, state_o = 2'd0.
- Per-button conditioner, identical for Run and Continue:
  - 2-flop synchroniser.
  - Counter clears whenever sync level equals debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
  - A rise pulse is one cycle, on the 0->1 transition of the debounced level.
  - Latency from a clean raw rise to the rise pulse: 2 + DEBOUNCE_CYCLES cycles; the pulse is registered.
  - A held button gives exactly one pulse; the next pulse needs a release (debounced to 0) first.
- FSM states (state_o encoding): IDLE=0, RUN=1, PAUSE=2, RESUME=3. All transitions registered.
  - Any state, run_rise: go to RUN; start_pulse=1 that cycle (registered output, coincident with entering RUN). This restarts the CPU even mid-run or while paused.
  - RUN: pause_req=1 and no run_rise -> PAUSE; cpu_en drops in the same cycle state becomes PAUSE.
  - PAUSE: cont_rise and no run_rise -> RESUME; cont_pulse=1 while in RESUME.
  - RESUME: lasts exactly one cycle, then RUN. cpu_en=1 and pause_req is ignored, giving the CPU one cycle to drop pause_req.
  - IDLE/RUN/RESUME: cont_rise ignored (no pulse, no state change).
- Output rules:
  - cpu_en = (state==RUN || state==RESUME).
  - start_pulse and cont_pulse are never high in the same cycle.
- Priority when events coincide: run_rise > cont_rise > pause_req.
- If pause_req is still high in the first RUN cycle after RESUME, the FSM re-enters PAUSE. This is legal and requires another Continue.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0, including any in-flight pulse. Partially counted debounce is discarded.

Decomposition:
- Shared package slc3_pkg:
  - typedef enum logic [1:0] run_state_t {IDLE, RUN, PAUSE, RESUME};
  - localparam default DEBOUNCE_CYCLES.
- Sub-module btn_conditioner (parameter DEBOUNCE_CYCLES). Ports Clk, Reset_n, btn_raw, level, rise. Instantiated twice.

Test Plan:
- Reset then Run held high 10 cycles (DEBOUNCE_CYCLES=4) -> start_pulse high exactly one cycle, 6 cycles after the first Clk edge sampling Run=1; state_o=1; cpu_en=1 thereafter.
- Run glitch high for 2 cycles -> no start_pulse, run_db stays 0, state_o stays 0.
- In RUN, pause_req=1 -> next cycle state_o=2, cpu_en=0. Continue pressed 8 cycles -> one cont_pulse cycle with state_o=3. pause_req dropped -> state_o=1.
- In PAUSE, Run and Continue rise together -> start_pulse=1, cont_pulse=0, state_o=1.
- Continue pressed in IDLE and in RUN -> no cont_pulse, state unchanged. Held Continue in PAUSE -> exactly one cont_pulse.
- Reset_n pulled low asynchronously in RESUME -> outputs 0 and state_o=0 before the next Clk edge; nothing happens after release until a fresh Run press.
